// File: rtl/pipeline_stage_register_pkg.sv
// Shared types for pipeline stage registers: skid FSM states, occupancy width, stage control bundles.
// Build option PIPE_REG_SKID_EN (see pipeline_stage_register) selects the two-entry variant.
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_TWO   = 2'd2
  } pipe_state_t;

  localparam int OCC_W = 2;

  // Decode/execute control bundle; every field must be harmless when all-zero.
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic [3:0] alu_op;
  } de_ctrl_t;

  localparam int DE_CTRL_W = $bits(de_ctrl_t);

  function automatic logic [OCC_W-1:0] state_occupancy(input pipe_state_t s);
    case (s)
      PS_ONE:  return 2'd1;
      PS_TWO:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipeline_stage_register_if.sv
// One valid/ready link between pipeline stages carrying a control and a data bundle.
// master drives valid/ctrl/data, slave drives ready.
interface pipeline_stage_register_if #(
  parameter int CTRL_W = 11,
  parameter int DATA_W = 192
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input ready);
  modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipeline_stage_register_entry.sv
// One register slot (valid, ctrl, data). clear wins over load; a cleared slot shows the bubble
// control word and keeps its stale data.
module pipe_reg_entry #(
  parameter int                 CTRL_W      = 11,
  parameter int                 DATA_W      = 192,
  parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_BUBBLE;
    end else if (load_i) begin
      valid_d = 1'b1;
      ctrl_d  = ctrl_i;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_BUBBLE;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipeline_stage_register.sv
// Elastic pipeline stage register with stall/flush; outputs straight from head flops, 1-cycle latency.
// Default: single entry, out_ready->in_ready combinational. PIPE_REG_SKID_EN: two-entry skid, registered in_ready.
module pipeline_stage_register
  import pipe_pkg::*;
#(
  parameter int                 CTRL_W      = 11,
  parameter int                 DATA_W      = 192,
  parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall_i,
  input  logic                        flush_i,
  pipeline_stage_register_if.slave    in_if,
  pipeline_stage_register_if.master   out_if,
  output logic [OCC_W-1:0]            occupancy_o
);

  logic              in_fire, out_fire;
  logic              head_load, head_clear;
  logic              head_vld;
  logic [CTRL_W-1:0] head_ctrl, head_ctrl_in;
  logic [DATA_W-1:0] head_data, head_data_in;

  assign in_fire  = in_if.valid & in_if.ready;
  assign out_fire = head_vld & out_if.ready & ~stall_i & ~flush_i;

  pipe_reg_entry #(
    .CTRL_W      (CTRL_W),
    .DATA_W      (DATA_W),
    .CTRL_BUBBLE (CTRL_BUBBLE)
  ) u_head (
    .clk     (clk),
    .rst     (rst),
    .load_i  (head_load),
    .clear_i (head_clear),
    .ctrl_i  (head_ctrl_in),
    .data_i  (head_data_in),
    .valid_o (head_vld),
    .ctrl_o  (head_ctrl),
    .data_o  (head_data)
  );

`ifdef PIPE_REG_SKID_EN

  pipe_state_t       state_q, state_d;
  logic              skid_load, skid_clear;
  logic              skid_vld;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  pipe_reg_entry #(
    .CTRL_W      (CTRL_W),
    .DATA_W      (DATA_W),
    .CTRL_BUBBLE (CTRL_BUBBLE)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .ctrl_i  (in_if.ctrl),
    .data_i  (in_if.data),
    .valid_o (skid_vld),
    .ctrl_o  (skid_ctrl),
    .data_o  (skid_data)
  );

  assign in_if.ready = ~stall_i & ~flush_i & (state_q != PS_TWO);

  // The skid slot is only occupied in PS_TWO, so its valid bit selects the head refill source.
  assign head_ctrl_in = skid_vld ? skid_ctrl : in_if.ctrl;
  assign head_data_in = skid_vld ? skid_data : in_if.data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PS_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    head_load  = 1'b0;
    head_clear = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (flush_i) begin
      state_d    = PS_EMPTY;
      head_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state_q)
        PS_EMPTY: begin
          if (in_fire) begin
            head_load = 1'b1;
            state_d   = PS_ONE;
          end
        end
        PS_ONE: begin
          if (in_fire && !out_fire) begin
            skid_load = 1'b1;
            state_d   = PS_TWO;
          end else if (out_fire && !in_fire) begin
            head_clear = 1'b1;
            state_d    = PS_EMPTY;
          end else if (in_fire && out_fire) begin
            head_load = 1'b1;
          end
        end
        PS_TWO: begin
          if (out_fire) begin
            head_load  = 1'b1;
            skid_clear = 1'b1;
            state_d    = PS_ONE;
          end
        end
        default: begin
          state_d    = PS_EMPTY;
          head_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  assign occupancy_o = state_occupancy(state_q);

`else

  assign in_if.ready  = ~stall_i & ~flush_i & (~head_vld | out_if.ready);
  assign head_ctrl_in = in_if.ctrl;
  assign head_data_in = in_if.data;
  assign head_load    = in_fire;
  // A drain without a simultaneous refill leaves a bubble behind.
  assign head_clear   = flush_i | (out_fire & ~in_fire);
  assign occupancy_o  = {{(OCC_W-1){1'b0}}, head_vld};

`endif

  assign out_if.valid = head_vld;
  assign out_if.ctrl  = head_ctrl;
  assign out_if.data  = head_data;

endmodule

// File: tb/tb_pipeline_stage_register.sv
// Scoreboard bench for pipeline_stage_register; build with and without PIPE_REG_SKID_EN.
module tb_pipeline_stage_register;
  import pipe_pkg::*;

  localparam int              CW  = DE_CTRL_W;
  localparam int              DW  = 192;
  localparam logic [CW-1:0]   BUB = 11'h5A5;
`ifdef PIPE_REG_SKID_EN
  localparam int              DEPTH = 2;
`else
  localparam int              DEPTH = 1;
`endif

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             stall = 1'b0;
  logic             flush = 1'b0;
  logic [OCC_W-1:0] occ;

  pipeline_stage_register_if #(.CTRL_W(CW), .DATA_W(DW)) in_if ();
  pipeline_stage_register_if #(.CTRL_W(CW), .DATA_W(DW)) out_if ();

  pipeline_stage_register #(
    .CTRL_W      (CW),
    .DATA_W      (DW),
    .CTRL_BUBBLE (BUB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall_i     (stall),
    .flush_i     (flush),
    .in_if       (in_if),
    .out_if      (out_if),
    .occupancy_o (occ)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  ent_t sb[$];

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t mk_val(input int unsigned v);
    ent_t e;
    e.c = CW'($urandom);
    e.d = DW'(v);
    return e;
  endfunction

  function automatic ent_t mk_rand();
    ent_t e;
    e.c = CW'($urandom);
    e.d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return e;
  endfunction

  // Drive one cycle of inputs, check against the model away from the edge, then advance.
  task automatic step(input logic v, input ent_t e, input logic ordy, input logic st,
                      input logic fl, output logic fired);
    logic exp_rdy, in_fire, out_fire;
    ent_t head;
    in_if.valid  = v;
    in_if.ctrl   = e.c;
    in_if.data   = e.d;
    out_if.ready = ordy;
    stall        = st;
    flush        = fl;
    @(negedge clk);
`ifdef PIPE_REG_SKID_EN
    exp_rdy = !st && !fl && (sb.size() < 2);
`else
    exp_rdy = !st && !fl && (sb.size() == 0 || ordy);
`endif
    check_eq("in_ready", in_if.ready, exp_rdy);
    check_eq("out_valid", out_if.valid, sb.size() != 0);
    check_eq("occupancy", occ, sb.size());
    if (!out_if.valid) check_eq("bubble_ctrl", out_if.ctrl, BUB);
    if (out_if.valid && sb.size() != 0) begin
      head = sb[0];
      check_eq("out_ctrl", out_if.ctrl, head.c);
      check_eq("out_data", out_if.data, head.d);
    end
    out_fire = out_if.valid & ordy & ~st & ~fl;
    in_fire  = in_if.valid & in_if.ready;
    if (out_fire && sb.size() != 0) void'(sb.pop_front());
    if (fl) sb.delete();
    if (in_fire) sb.push_back(e);
    fired = in_fire;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic fired;
    ent_t pend;
    ent_t items[3];
    int   idx;

    in_if.valid  = 1'b0;
    in_if.ctrl   = '0;
    in_if.data   = '0;
    out_if.ready = 1'b0;

    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_valid", out_if.valid, 1'b0);
    check_eq("rst_ctrl", out_if.ctrl, BUB);
    check_eq("rst_data", out_if.data, '0);
    check_eq("rst_occ", occ, 0);
    check_eq("rst_in_ready", in_if.ready, 1'b1);
    @(posedge clk);
    #1;

    // Streaming 1..4 with full throughput
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, mk_val(i), 1'b1, 1'b0, 1'b0, fired);
      check_eq("stream_accept", fired, 1'b1);
      check_eq("stream_latency", out_if.data, DW'(i));
    end
    repeat (2) step(1'b0, mk_val(0), 1'b1, 1'b0, 1'b0, fired);

    // Backpressure A,B,C
    items[0] = mk_val(32'hA);
    items[1] = mk_val(32'hB);
    items[2] = mk_val(32'hC);
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      if (c == 4) begin
        check_eq("bp_full_occ", occ, DEPTH);
        check_eq("bp_in_ready", in_if.ready, 1'b0);
        check_eq("bp_head", out_if.data, DW'(32'hA));
      end
      step(idx < 3, items[idx < 3 ? idx : 2], c >= 5, 1'b0, 1'b0, fired);
      if (fired) idx++;
    end
    check_eq("bp_all_taken", idx, 3);
    check_eq("bp_drained", occ, 0);

    // Flush with entries held and input pending
    step(1'b1, mk_val(32'h11), 1'b0, 1'b0, 1'b0, fired);
    step(1'b1, mk_val(32'h12), 1'b0, 1'b0, 1'b0, fired);
    step(1'b1, mk_val(32'h13), 1'b0, 1'b0, 1'b1, fired);
    check_eq("flush_in_taken", fired, 1'b0);
    check_eq("flush_occ", occ, 0);
    check_eq("flush_valid", out_if.valid, 1'b0);
    check_eq("flush_ctrl", out_if.ctrl, BUB);

    // Stall holding head 5 with 6 pending
    step(1'b1, mk_val(5), 1'b0, 1'b0, 1'b0, fired);
    pend = mk_val(6);
    for (int c = 0; c < 3; c++) begin
      step(1'b1, pend, 1'b1, 1'b1, 1'b0, fired);
      check_eq("stall_no_accept", fired, 1'b0);
      check_eq("stall_hold", out_if.data, DW'(5));
    end
    step(1'b1, pend, 1'b1, 1'b0, 1'b0, fired);
    check_eq("stall_release_accept", fired, 1'b1);
    check_eq("stall_next", out_if.data, DW'(6));
    repeat (2) step(1'b0, pend, 1'b1, 1'b0, 1'b0, fired);

    // Random traffic against the scoreboard
    pend = mk_rand();
    for (int c = 0; c < 10000; c++) begin
      step(($urandom % 4) != 0, pend, ($urandom % 3) != 0, ($urandom % 10) == 0,
           ($urandom % 40) == 0, fired);
      if (fired) pend = mk_rand();
    end
    repeat (4) step(1'b0, pend, 1'b1, 1'b0, 1'b0, fired);
    check_eq("final_empty", occ, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
